// File: rtl/ifetch_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ifetch_queue                                                  |
// | Purpose  : Decoupled instruction-fetch stage. Issues sequential word     |
// |            fetches to a 1-cycle synchronous instruction memory, buffers  |
// |            returned words with their PCs in a DEPTH-entry circular queue |
// |            and hands them to decode over a valid/ready handshake.        |
// |            A later stage steers the PC through Redirect; unconditional   |
// |            J instructions are optionally followed inside fetch.          |
// | Ports    : Clk/Clr          clock, async active-high reset               |
// |            Imem_Req/Addr    fetch request and word address              |
// |            Imem_Rdata       instruction for last cycle's request         |
// |            Redirect/_PC     flush queue and restart fetch                |
// |            Inst_Valid/Ready decode handshake on the queue head           |
// |            Inst/Inst_PC     head instruction and its PC                  |
// |            Inst_Pred        head is a J already followed by fetch        |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module ifetch_queue #(
   parameter int unsigned DEPTH       = 4,
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter bit          PREDECODE_J = 1'b1
) (
   input  logic        Clk,
   input  logic        Clr,
   output logic        Imem_Req,
   output logic [31:0] Imem_Addr,
   input  logic [31:0] Imem_Rdata,
   input  logic        Redirect,
   input  logic [31:0] Redirect_PC,
   output logic        Inst_Valid,
   input  logic        Inst_Ready,
   output logic [31:0] Inst,
   output logic [31:0] Inst_PC,
   output logic        Inst_Pred
);

   localparam int unsigned        c_PTR_W    = $clog2(DEPTH);
   localparam int unsigned        c_CNT_W    = $clog2(DEPTH + 1);
   localparam logic [5:0]         c_OP_J     = 6'b000010;
   localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
   localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(DEPTH);
   localparam logic [c_CNT_W:0]   c_CREDIT   = (c_CNT_W + 1)'(DEPTH);

   logic [31:0]        fpc_q, fpc_d;
   logic               if_v_q, if_v_d;
   logic [31:0]        if_pc_q, if_pc_d;
   logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [c_CNT_W-1:0] count_q, count_d;

   logic [31:0]        mem_inst [DEPTH];
   logic [31:0]        mem_pc   [DEPTH];
   logic [DEPTH-1:0]   mem_pred;

   logic               w_valid;
   logic               w_pop;
   logic               w_push;
   logic               w_jdet;
   logic               w_req;
   logic [c_CNT_W:0]   w_credit;
   logic               w_unused_bits;

   // Low redirect bits are forced to zero and never looked at.
   assign w_unused_bits = &{1'b0, Redirect_PC[1:0]};

   always_comb begin
      w_valid  = (count_q != '0);
      w_pop    = w_valid & Inst_Ready & ~Redirect;
      w_push   = if_v_q & ~Redirect;
      w_jdet   = PREDECODE_J & if_v_q & ~Redirect & (Imem_Rdata[31:26] == c_OP_J);
      // Slots already owned (queued + in flight) after this cycle's pop; a new
      // request is only issued when its response is guaranteed a free slot.
      w_credit = {1'b0, count_q}
               + {{c_CNT_W{1'b0}}, if_v_q}
               - {{c_CNT_W{1'b0}}, w_pop};
      // The cycle a J arrives is spent steering FPC to its target.
      w_req    = ~Redirect & ~w_jdet & (w_credit < c_CREDIT);
   end

   always_comb begin
      fpc_d    = fpc_q;
      if_v_d   = w_req;
      if_pc_d  = fpc_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (Redirect) begin
         fpc_d    = {Redirect_PC[31:2], 2'b00};
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (w_jdet) begin
            fpc_d = {if_pc_q[31:28], Imem_Rdata[25:0], 2'b00};
         end else if (w_req) begin
            fpc_d = fpc_q + 32'd4;
         end
         if (w_push) begin
            wr_ptr_d = wr_ptr_q + c_PTR_ONE;
         end
         if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_PTR_ONE;
         end
         case ({w_push, w_pop})
            2'b10:   count_d = count_q + c_CNT_ONE;
            2'b01:   count_d = count_q - c_CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge Clk or posedge Clr) begin
      if (Clr) begin
         fpc_q    <= RESET_PC;
         if_v_q   <= 1'b0;
         if_pc_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         fpc_q    <= fpc_d;
         if_v_q   <= if_v_d;
         if_pc_q  <= if_pc_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage needs no reset: the count alone says which slots are live.
   always_ff @(posedge Clk) begin
      if (w_push) begin
         mem_inst[wr_ptr_q] <= Imem_Rdata;
         mem_pc[wr_ptr_q]   <= if_pc_q;
         mem_pred[wr_ptr_q] <= w_jdet;
      end
   end

   // Head outputs read as zero when empty, matching the reset values.
   always_comb begin
      Imem_Req   = w_req;
      Imem_Addr  = fpc_q;
      Inst_Valid = w_valid;
      Inst       = w_valid ? mem_inst[rd_ptr_q] : 32'h0;
      Inst_PC    = w_valid ? mem_pc[rd_ptr_q]   : 32'h0;
      Inst_Pred  = w_valid ? mem_pred[rd_ptr_q] : 1'b0;
   end

`ifndef SYNTHESIS
   // The issue credit makes a push into a full queue impossible.
   a_no_overflow : assert property (@(posedge Clk) disable iff (Clr)
      !(w_push && !w_pop && (count_q == c_CNT_FULL)));
`endif

endmodule
`default_nettype wire

// File: tb/tb_ifetch_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_ifetch_queue                                               |
// | Purpose  : Self-checking bench for ifetch_queue: a queue-based reference |
// |            model checked every cycle, directed scenarios with literal    |
// |            expectations, then randomized ready/redirect/reset traffic.   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_ifetch_queue;

   localparam int unsigned c_DEPTH    = 4;
   localparam logic [31:0] c_RESET_PC = 32'h0000_0000;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
      bit          pred;
   } ent_t;

   logic        Clk = 1'b0;
   logic        Clr = 1'b1;
   logic        Imem_Req;
   logic [31:0] Imem_Addr;
   logic [31:0] Imem_Rdata = '0;
   logic        Redirect = 1'b0;
   logic [31:0] Redirect_PC = '0;
   logic        Inst_Valid;
   logic        Inst_Ready = 1'b0;
   logic [31:0] Inst;
   logic [31:0] Inst_PC;
   logic        Inst_Pred;

   ifetch_queue #(
      .DEPTH       (c_DEPTH),
      .RESET_PC    (c_RESET_PC),
      .PREDECODE_J (1'b1)
   ) dut (
      .Clk         (Clk),
      .Clr         (Clr),
      .Imem_Req    (Imem_Req),
      .Imem_Addr   (Imem_Addr),
      .Imem_Rdata  (Imem_Rdata),
      .Redirect    (Redirect),
      .Redirect_PC (Redirect_PC),
      .Inst_Valid  (Inst_Valid),
      .Inst_Ready  (Inst_Ready),
      .Inst        (Inst),
      .Inst_PC     (Inst_PC),
      .Inst_Pred   (Inst_Pred)
   );

   always #5 Clk = ~Clk;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   // reference model state
   ent_t        mq[$];
   logic [31:0] m_fpc;
   bit          m_ifv;
   logic [31:0] m_ifpc;

   // memory environment
   bit          mem_pend;
   logic [31:0] mem_addr;
   bit          j_en = 1'b0;

   // observations of the last stepped cycle
   logic        obs_req, obs_valid, obs_pred;
   logic [31:0] obs_addr, obs_pc, obs_inst;
   logic [31:0] acc_pc[$];
   bit          acc_pred[$];

   function automatic logic [31:0] rom(input logic [31:0] a);
      if (a == 32'h1000_0008) return {6'b000010, 26'h000_0040};
      if (j_en && ((a[4:2] ^ a[9:7]) == 3'd5))
         return {6'b000010, 12'h000, a[13:2] ^ 12'h5A3, 2'b00};
      return {6'h23, a[27:2]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_fpc    = c_RESET_PC;
      m_ifv    = 1'b0;
      m_ifpc   = '0;
      mem_pend = 1'b0;
   endtask

   // One clock cycle: drive inputs, compare every output against the model,
   // then advance the model.
   task automatic step(input bit rdy, input bit rd, input logic [31:0] rpc);
      bit          m_valid, m_pop, m_jdet, m_req;
      int          occ;
      logic [31:0] nf;
      ent_t        e;
      @(negedge Clk);
      Inst_Ready  = rdy;
      Redirect    = rd;
      Redirect_PC = rpc;
      Imem_Rdata  = mem_pend ? rom(mem_addr) : $urandom;
      #1;
      m_valid = (mq.size() != 0);
      m_pop   = m_valid && rdy && !rd;
      m_jdet  = m_ifv && !rd && (Imem_Rdata[31:26] == 6'b000010);
      occ     = mq.size() + (m_ifv ? 1 : 0) - (m_pop ? 1 : 0);
      m_req   = !rd && !m_jdet && (occ < c_DEPTH);

      chk("imem_req", {31'b0, Imem_Req}, {31'b0, m_req});
      chk("inst_valid", {31'b0, Inst_Valid}, {31'b0, m_valid});
      if (m_req) chk("imem_addr", Imem_Addr, m_fpc);
      if (m_valid) begin
         chk("inst", Inst, mq[0].inst);
         chk("inst_pc", Inst_PC, mq[0].pc);
         chk("inst_pred", {31'b0, Inst_Pred}, {31'b0, mq[0].pred});
      end

      obs_req = Imem_Req;  obs_addr = Imem_Addr; obs_valid = Inst_Valid;
      obs_pc  = Inst_PC;   obs_inst = Inst;      obs_pred  = Inst_Pred;
      if (Inst_Valid && rdy && !rd) begin
         acc_pc.push_back(Inst_PC);
         acc_pred.push_back(Inst_Pred);
      end
      mem_pend = Imem_Req;
      mem_addr = Imem_Addr;

      if (rd) begin
         mq.delete();
         m_fpc = rpc & 32'hFFFF_FFFC;
         m_ifv = 1'b0;
      end else begin
         if (m_pop) mq.delete(0);
         if (m_ifv) begin
            e.inst = Imem_Rdata; e.pc = m_ifpc; e.pred = m_jdet;
            mq.push_back(e);
         end
         nf     = m_jdet ? {m_ifpc[31:28], Imem_Rdata[25:0], 2'b00}
                         : (m_req ? m_fpc + 32'd4 : m_fpc);
         m_ifpc = m_fpc;
         m_ifv  = m_req;
         m_fpc  = nf;
      end
   endtask

   // Asynchronous reset pulse spanning one rising edge, starting mid-cycle.
   task automatic clr_pulse();
      #1 Clr = 1'b1;
      #1;
      chk("clr_inst_valid", {31'b0, Inst_Valid}, 32'h0);
      chk("clr_inst_pc", Inst_PC, 32'h0);
      #4 Clr = 1'b0;
      model_reset();
   endtask

   function automatic logic [31:0] acc_at(input int i);
      if (i < acc_pc.size()) return acc_pc[i];
      return 32'hDEAD_BEEF;
   endfunction

   initial begin
      int  nreq;
      bit  found;
      bit  rdy;
      bit  rd;
      logic [31:0] rpc;

      model_reset();
      #7 Clr = 1'b0;

      // Streaming from reset, decode always ready.
      for (int c = 0; c < 12; c++) begin
         step(1'b1, 1'b0, 32'h0);
         if (c == 0) begin
            chk("s1_first_req", {31'b0, obs_req}, 32'h1);
            chk("s1_first_addr", obs_addr, c_RESET_PC);
         end
         if (c == 1) chk("s1_valid_c1", {31'b0, obs_valid}, 32'h0);
         if (c >= 2) begin
            chk("s1_valid", {31'b0, obs_valid}, 32'h1);
            chk("s1_pc", obs_pc, 32'(4 * (c - 2)));
            chk("s1_inst", obs_inst, rom(32'(4 * (c - 2))));
         end
      end
      clr_pulse();

      // Back-pressure: exactly DEPTH requests, then drain in order.
      nreq = 0;
      for (int c = 0; c < 8; c++) begin
         step(1'b0, 1'b0, 32'h0);
         if (obs_req) nreq++;
      end
      chk("s2_req_count", 32'(nreq), 32'd4);
      chk("s2_req_stopped", {31'b0, obs_req}, 32'h0);
      acc_pc.delete(); acc_pred.delete();
      step(1'b1, 1'b0, 32'h0);
      chk("s2_resume_req", {31'b0, obs_req}, 32'h1);
      chk("s2_resume_addr", obs_addr, 32'h10);
      for (int c = 0; c < 4; c++) step(1'b1, 1'b0, 32'h0);
      for (int i = 0; i < 4; i++) chk("s2_drain_pc", acc_at(i), 32'(4 * i));

      // Redirect while entries are held.
      for (int c = 0; c < 6; c++) step(1'b0, 1'b0, 32'h0);
      step(1'b1, 1'b1, 32'h0000_1003);
      chk("s3_no_req_R", {31'b0, obs_req}, 32'h0);
      step(1'b1, 1'b0, 32'h0);
      chk("s3_valid_R1", {31'b0, obs_valid}, 32'h0);
      chk("s3_addr_R1", obs_addr, 32'h0000_1000);
      step(1'b1, 1'b0, 32'h0);
      chk("s3_valid_R2", {31'b0, obs_valid}, 32'h0);
      step(1'b1, 1'b0, 32'h0);
      chk("s3_valid_R3", {31'b0, obs_valid}, 32'h1);
      chk("s3_pc_R3", obs_pc, 32'h0000_1000);

      // J followed inside fetch.
      acc_pc.delete(); acc_pred.delete();
      step(1'b1, 1'b1, 32'h1000_0000);
      for (int c = 0; c < 10; c++) step(1'b1, 1'b0, 32'h0);
      chk("s4_pc0", acc_at(0), 32'h1000_0000);
      chk("s4_pc1", acc_at(1), 32'h1000_0004);
      chk("s4_pc2", acc_at(2), 32'h1000_0008);
      chk("s4_pc3", acc_at(3), 32'h1000_0100);
      chk("s4_pc4", acc_at(4), 32'h1000_0104);
      if (acc_pred.size() > 2) begin
         chk("s4_pred_j", {31'b0, acc_pred[2]}, 32'h1);
         chk("s4_pred_seq", {31'b0, acc_pred[1]}, 32'h0);
      end else begin
         chk("s4_pred_count", 32'(acc_pred.size()), 32'd3);
      end
      found = 1'b0;
      foreach (acc_pc[i]) if (acc_pc[i] == 32'h1000_000C) found = 1'b1;
      chk("s4_no_fallthrough", {31'b0, found}, 32'h0);

      // Redirect colliding with a J response and a decode handshake.
      acc_pc.delete(); acc_pred.delete();
      step(1'b1, 1'b1, 32'h1000_0000);
      for (int c = 0; c < 3; c++) step(1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b1, 32'h0000_2000);
      chk("s5_head_valid", {31'b0, obs_valid}, 32'h1);
      chk("s5_head_pc", obs_pc, 32'h1000_0004);
      chk("s5_no_req", {31'b0, obs_req}, 32'h0);
      step(1'b1, 1'b0, 32'h0);
      chk("s5_restart_addr", obs_addr, 32'h0000_2000);
      for (int c = 0; c < 5; c++) step(1'b1, 1'b0, 32'h0);
      chk("s5_acc0", acc_at(0), 32'h1000_0000);
      chk("s5_acc1", acc_at(1), 32'h0000_2000);

      // Address wrap, then reset mid-stream.
      step(1'b1, 1'b1, 32'hFFFF_FFF8);
      step(1'b1, 1'b0, 32'h0);
      chk("s6_addr_fff8", obs_addr, 32'hFFFF_FFF8);
      step(1'b1, 1'b0, 32'h0);
      chk("s6_addr_fffc", obs_addr, 32'hFFFF_FFFC);
      step(1'b1, 1'b0, 32'h0);
      chk("s6_addr_wrap", obs_addr, 32'h0000_0000);
      step(1'b1, 1'b0, 32'h0);
      chk("s6_valid_before_clr", {31'b0, obs_valid}, 32'h1);
      clr_pulse();
      step(1'b1, 1'b0, 32'h0);
      chk("s6_restart_req", {31'b0, obs_req}, 32'h1);
      chk("s6_restart_addr", obs_addr, c_RESET_PC);

      // Randomized traffic with J instructions present in memory.
      j_en = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if (((i / 200) % 2) == 1) rdy = (($urandom % 4) == 0);
         else                      rdy = (($urandom % 4) != 0);
         rd  = (($urandom % 32) == 0);
         rpc = $urandom & 32'h0000_3FFF;
         step(rdy, rd, rpc);
         if (($urandom % 500) == 0) clr_pulse();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
